// File: rtl/hht_mem_responder.sv
// Dual-read-port data memory with a CPU write port, a 32-entry base-register
// file with two combinational read ports, a sticky out-of-range flag and a
// running count of accepted read requests.
module hht_mem_responder #(
  parameter int unsigned DEPTH     = 512,
  parameter logic [31:0] MISS_DATA = 32'd99999
) (
  input  logic        Clk,
  input  logic        Rst,

  input  logic        rd1_req,
  input  logic [31:0] rd1_addr,
  output logic [31:0] rd1_data,
  output logic        rd1_valid,

  input  logic        rd2_req,
  input  logic [31:0] rd2_addr,
  output logic [31:0] rd2_data,
  output logic        rd2_valid,

  input  logic [4:0]  regaddr1,
  output logic [31:0] base_dat_a,
  input  logic [4:0]  regaddr2,
  output logic [31:0] base_dat_b,

  input  logic        WR,
  input  logic        wr_sel,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_data,

  input  logic        clr_err,
  output logic        oob_err,
  output logic [15:0] rd_count
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  // Storage
  logic [31:0] mem_q  [DEPTH];
  logic [31:0] regs_q [32];

  // Read-port and status state
  logic [31:0] rd1_data_q, rd1_data_d;
  logic        rd1_valid_q, rd1_valid_d;
  logic [31:0] rd2_data_q, rd2_data_d;
  logic        rd2_valid_q, rd2_valid_d;
  logic        oob_err_q, oob_err_d;
  logic [15:0] rd_count_q, rd_count_d;

  // Decoded access qualifiers
  logic rd1_in_range, rd2_in_range, wr_in_range;
  logic mem_we, reg_we, oob_set;

  // Classify each access against the memory bounds
  always_comb begin
    rd1_in_range = (rd1_addr < DEPTH_W);
    rd2_in_range = (rd2_addr < DEPTH_W);
    wr_in_range  = (cpu_addr < DEPTH_W);
    mem_we       = WR & ~wr_sel & wr_in_range;
    // Register 0 is hardwired to zero, so writes to it are simply not enabled
    reg_we       = WR & wr_sel & (cpu_addr[4:0] != 5'd0);
    oob_set      = (rd1_req & ~rd1_in_range) |
                   (rd2_req & ~rd2_in_range) |
                   (WR & ~wr_sel & ~wr_in_range);
  end

  // Next-state for read ports, error flag and request counter
  always_comb begin
    rd1_valid_d = rd1_req;
    rd1_data_d  = rd1_data_q;
    if (rd1_req) begin
      rd1_data_d = rd1_in_range ? mem_q[rd1_addr[AW-1:0]] : MISS_DATA;
    end

    rd2_valid_d = rd2_req;
    rd2_data_d  = rd2_data_q;
    if (rd2_req) begin
      rd2_data_d = rd2_in_range ? mem_q[rd2_addr[AW-1:0]] : MISS_DATA;
    end

    // A new out-of-range access wins over a simultaneous clear
    oob_err_d  = oob_set | (oob_err_q & ~clr_err);
    rd_count_d = rd_count_q + {15'd0, rd1_req} + {15'd0, rd2_req};
  end

  // Read-port, error and counter registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rd1_data_q  <= '0;
      rd1_valid_q <= 1'b0;
      rd2_data_q  <= '0;
      rd2_valid_q <= 1'b0;
      oob_err_q   <= 1'b0;
      rd_count_q  <= '0;
    end else begin
      rd1_data_q  <= rd1_data_d;
      rd1_valid_q <= rd1_valid_d;
      rd2_data_q  <= rd2_data_d;
      rd2_valid_q <= rd2_valid_d;
      oob_err_q   <= oob_err_d;
      rd_count_q  <= rd_count_d;
    end
  end

  // Data memory write; contents are deliberately left untouched by reset
  always_ff @(posedge Clk or negedge Rst) begin
    if (Rst && mem_we) begin
      mem_q[cpu_addr[AW-1:0]] <= cpu_data;
    end
  end

  // Base-register file; entry 0 stays at its reset value of zero
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (reg_we) begin
      regs_q[cpu_addr[4:0]] <= cpu_data;
    end
  end

  // Outputs straight from the flops
  always_comb begin
    rd1_data   = rd1_data_q;
    rd1_valid  = rd1_valid_q;
    rd2_data   = rd2_data_q;
    rd2_valid  = rd2_valid_q;
    oob_err    = oob_err_q;
    rd_count   = rd_count_q;
    base_dat_a = regs_q[regaddr1];
    base_dat_b = regs_q[regaddr2];
  end

endmodule

// File: doc/hht_mem_responder.md
HHT_MEM_RESPONDER -- requirements
Module: hht_mem_responder

Interface
REQ-001 Parameter DEPTH, default 512: number of 32-bit data-memory words; valid word addresses are 0..DEPTH-1.
REQ-002 Parameter MISS_DATA, default 32'd99999: value returned for any read outside 0..DEPTH-1.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-low.
REQ-005 rd1_req  input  1  read request, port 1.
REQ-006 rd1_addr  input  32  read word address, port 1.
REQ-007 rd1_data  output  32  read data, port 1.
REQ-008 rd1_valid  output  1  rd1_data valid strobe.
REQ-009 rd2_req / rd2_addr / rd2_data / rd2_valid  in/in/out/out  1/32/32/1  second read port, identical to port 1.
REQ-010 regaddr1  input  5  base-register select, port A.
REQ-011 base_dat_a  output  32  base register contents, port A.
REQ-012 regaddr2  input  5  base-register select, port B.
REQ-013 base_dat_b  output  32  base register contents, port B.
REQ-014 WR  input  1  CPU write strobe.
REQ-015 wr_sel  input  1  write target: 0 = data memory, 1 = register file.
REQ-016 cpu_addr  input  32  write address (memory word, or register index in bits [4:0]).
REQ-017 cpu_data  input  32  write data.
REQ-018 clr_err  input  1  clears oob_err.
REQ-019 oob_err  output  1  sticky out-of-range access flag.
REQ-020 rd_count  output  16  count of accepted read requests, both ports.

Function
REQ-021 Read latency: rd1_req sampled high at edge N -> rd1_data and rd1_valid=1 registered at edge N; visible throughout cycle N+1.
REQ-022 rd1_valid shall be 0 in any cycle following an edge with rd1_req=0; rd1_data shall hold its last value.
REQ-023 One request accepted per port per cycle, back-to-back, no stall; the ports are fully independent.
REQ-024 In-range read returns mem[addr]; out-of-range (addr >= DEPTH) returns MISS_DATA with valid=1 and sets oob_err.
REQ-025 Both ports reading the same address in one cycle both return the same data.
REQ-026 Memory write: WR=1, wr_sel=0, cpu_addr < DEPTH -> mem[cpu_addr] <= cpu_data at the edge.
REQ-027 Out-of-range memory write: discarded, sets oob_err.
REQ-028 Read and write to the same address in the same cycle: read returns the old (pre-write) data.
REQ-029 Register write: WR=1, wr_sel=1 -> reg[cpu_addr[4:0]] <= cpu_data; cpu_addr[31:5] ignored; never sets oob_err.
REQ-030 base_dat_a = reg[regaddr1] and base_dat_b = reg[regaddr2], combinational from register flops.
REQ-031 Register 0 reads as 0; writes to it are discarded.
REQ-032 A register write is visible on base_dat_a/b in the cycle after the write edge; same-cycle reads show the old value.
REQ-033 oob_err: set at the edge of any out-of-range access, held until clr_err.
REQ-034 Set and clr_err in the same cycle: set wins.
REQ-035 rd_count: +0, +1 or +2 per edge by the number of requests accepted; wraps 16'hFFFF -> 0.

Reset
REQ-036 Rst low: immediately rd1_data = rd2_data = 0, rd1_valid = rd2_valid = 0, oob_err = 0, rd_count = 0, all registers = 0.
REQ-037 Memory array is not reset; contents survive Rst.
REQ-038 Rst asserted mid-operation: in-flight reads are dropped; no valid strobe after Rst deasserts without a new request.
REQ-039 Requests and writes are ignored while Rst is low.

Verification
REQ-040 Write mem[180]=2, mem[181]=6, then rd1_req at 180 and 181 back-to-back -> rd1_valid high two consecutive cycles, data 2 then 6.
REQ-041 Write reg6=180, reg8=2; regaddr1=6 -> base_dat_a=180; regaddr2=8 -> base_dat_b=2; regaddr1=0 -> 0 after writing reg0=55.
REQ-042 rd2_req addr 600 (DEPTH 512) -> rd2_data=99999, rd2_valid=1, oob_err=1 held; clr_err pulse -> 0; set plus clr in same cycle -> stays 1.
REQ-043 Same-cycle write mem[10]=98 (old value 0) and rd1 read at 10 -> returns 0; next read returns 98.
REQ-044 Both ports requesting for 3 cycles from reset -> rd_count=6; preset to 16'hFFFF, one request -> 0.
REQ-045 Assert Rst while requests are in flight -> all outputs 0 immediately; mem[180] still reads 2 afterwards.
